ddr_event_reader: RTL and testbench

- AXI4 burst-read master that pulls stored event data back out of DDR and presents it as an AXI4-Stream.
- Connects to the single-master readout slave port of the DDR interconnect. This is the read side complementing the header/input write masters.
- A command of (start address, beat count) is split into legal INCR bursts. Bursts never cross a 4 KB boundary and never exceed MAX_BURST.
- Space is reserved in an internal FIFO before each AR issue, so rready is held high and the R channel never stalls.

---
 rtl/ddr_event_reader.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_ddr_event_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_event_reader.sv
// ddr_event_reader
// ----------------
// AXI4 burst-read master that pulls stored event data back out of DDR and
// presents it as an AXI4-Stream. A command (start address, beat count) is
// split into INCR bursts that never cross a 4 KB page and never exceed
// MAX_BURST beats. FIFO space for each burst is reserved before its AR is
// issued, so rready can stay high and the R channel never stalls.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   cmd_addr/beats/valid   command input (low address bits forced to 0)
//   cmd_ready              command accept (IDLE only)
//   m_axi_ar*              AXI4 read-address channel (master)
//   m_axi_r*               AXI4 read-data channel (rready tied high)
//   m_axis_t*              AXI4-Stream output, tlast on final beat of command
//   done                   one-cycle pulse when a command completes
//   err                    sticky: bad rresp or rlast in the wrong position

module ddr_event_reader #(
    parameter int ADDR_WIDTH      = 34,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic                  m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,

    output logic                  done,
    output logic                  err
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG_BYTES  = $clog2(BYTES);
    localparam int PAGE_BEATS = 4096 / BYTES;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = PW + 1;
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [15:0]            total_q, total_d;
    logic [15:0]            streamed_q, streamed_d;
    logic [CW-1:0]          reserved_q, reserved_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic                   arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [15:0]            burst_q, burst_d;

    logic [DATA_WIDTH-1:0]  fifoMem [FIFO_DEPTH];
    logic [PW-1:0]          fwptr_q, fwptr_d;
    logic [PW-1:0]          frptr_q, frptr_d;
    logic [CW-1:0]          fcount_q, fcount_d;

    logic [7:0]             lenQueue [MAX_OUTSTANDING];
    logic [QW-1:0]          qwptr_q, qwptr_d;
    logic [QW-1:0]          qrptr_q, qrptr_d;
    logic [7:0]             rbeat_q, rbeat_d;

    logic [15:0]            pageBeats;
    logic [15:0]            burstCalc;
    logic                   canIssue;
    logic                   accept;
    logic                   arHs;
    logic                   rBeat;
    logic                   rLastHs;
    logic                   qNonEmpty;
    logic                   expectLast;
    logic                   rErr;
    logic                   fifoWr;
    logic                   pop;
    logic                   tvalidInt;
    logic                   unusedInputs;

    function automatic logic [QW-1:0] qNext(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // The read ID is fixed and the byte offset within a beat is discarded.
    assign unusedInputs = ^{m_axi_rid, cmd_addr[LOG_BYTES-1:0]};

    // Constant AR fields, and handshake qualifiers shared by the logic below.
    assign m_axi_arid    = 1'b0;
    assign m_axi_arsize  = 3'(LOG_BYTES);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_rready  = aresetn;

    assign cmd_ready = aresetn & (state_q == IDLE);
    assign accept    = (state_q == IDLE) & cmd_valid;
    assign arHs      = arvalid_q & m_axi_arready;
    assign rBeat     = m_axi_rvalid;
    assign rLastHs   = rBeat & m_axi_rlast;
    assign qNonEmpty = (outstanding_q != '0);

    // FWFT stream side: the head entry is visible whenever the FIFO holds data.
    // tdata is forced to zero while empty so nothing stale leaks out.
    assign tvalidInt     = (fcount_q != '0);
    assign pop           = tvalidInt & m_axis_tready;
    assign m_axis_tvalid = tvalidInt;
    assign m_axis_tdata  = tvalidInt ? fifoMem[frptr_q] : '0;
    assign m_axis_tlast  = tvalidInt & (streamed_q == total_q - 16'd1);
    assign done          = (state_q == DONE);
    assign err           = err_q;

    // Burst sizing: the smallest of what is left, the burst cap, and the
    // number of beats remaining before the next 4 KB page boundary.
    always_comb begin
        pageBeats = 16'(PAGE_BEATS) - 16'(addr_q[11:LOG_BYTES]);
        burstCalc = remaining_q;
        if (burstCalc > 16'(MAX_BURST)) begin
            burstCalc = 16'(MAX_BURST);
        end
        if (burstCalc > pageBeats) begin
            burstCalc = pageBeats;
        end
        canIssue = ((17'(reserved_q) + 17'(burstCalc)) <= 17'(FIFO_DEPTH)) &&
                   (outstanding_q < OW'(MAX_OUTSTANDING));
    end

    // R channel bookkeeping: each burst's arlen is queued in issue order so
    // that rlast can be checked against the beat position of the current burst.
    always_comb begin
        expectLast = (rbeat_q == lenQueue[qrptr_q]);
        rErr       = rBeat && ((m_axi_rresp != 2'b00) || !qNonEmpty ||
                               (m_axi_rlast != expectLast));
        rbeat_d    = rbeat_q;
        qrptr_d    = qrptr_q;
        qwptr_d    = qwptr_q;
        if (rBeat) begin
            rbeat_d = m_axi_rlast ? 8'd0 : rbeat_q + 8'd1;
        end
        if (rLastHs && qNonEmpty) begin
            qrptr_d = qNext(qrptr_q);
        end
        if (arHs) begin
            qwptr_d = qNext(qwptr_q);
        end
    end

    // Data FIFO pointers. Writes are only refused when full, which the
    // reservation scheme keeps from happening with a well-behaved slave.
    always_comb begin
        fifoWr   = rBeat && (fcount_q != CW'(FIFO_DEPTH));
        fwptr_d  = fifoWr ? fwptr_q + 1'b1 : fwptr_q;
        frptr_d  = pop ? frptr_q + 1'b1 : frptr_q;
        fcount_d = fcount_q + CW'(fifoWr) - CW'(pop);
    end

    // Command FSM plus the address/remaining/reservation counters.
    // DRAIN looks at the post-pop stream count so that done follows the final
    // stream handshake by a single cycle. A zero-length command passes through
    // DRAIN, where the completion test is already true.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        total_d       = total_q;
        streamed_d    = pop ? streamed_q + 16'd1 : streamed_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        burst_d       = burst_q;
        reserved_d    = reserved_q + (arHs ? CW'(burst_q) : '0) - CW'(pop);
        outstanding_d = outstanding_q + OW'(arHs) - OW'(rLastHs && qNonEmpty);
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = {cmd_addr[ADDR_WIDTH-1:LOG_BYTES], {LOG_BYTES{1'b0}}};
                    remaining_d = cmd_beats;
                    total_d     = cmd_beats;
                    streamed_d  = '0;
                    state_d     = (cmd_beats == 16'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!arvalid_q) begin
                    if (canIssue) begin
                        arvalid_d = 1'b1;
                        araddr_d  = addr_q;
                        arlen_d   = 8'(burstCalc - 16'd1);
                        burst_d   = burstCalc;
                    end
                end else if (arHs) begin
                    arvalid_d   = 1'b0;
                    addr_d      = addr_q + (ADDR_WIDTH'(burst_q) << LOG_BYTES);
                    remaining_d = remaining_q - burst_q;
                    if (remaining_q == burst_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (streamed_d == total_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            err_d = 1'b0;
        end
        if (rErr) begin
            err_d = 1'b1;
        end
    end

    // Control registers; reset abandons any in-flight transactions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            total_q       <= '0;
            streamed_q    <= '0;
            reserved_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            burst_q       <= '0;
            fwptr_q       <= '0;
            frptr_q       <= '0;
            fcount_q      <= '0;
            qwptr_q       <= '0;
            qrptr_q       <= '0;
            rbeat_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            total_q       <= total_d;
            streamed_q    <= streamed_d;
            reserved_q    <= reserved_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            burst_q       <= burst_d;
            fwptr_q       <= fwptr_d;
            frptr_q       <= frptr_d;
            fcount_q      <= fcount_d;
            qwptr_q       <= qwptr_d;
            qrptr_q       <= qrptr_d;
            rbeat_q       <= rbeat_d;
        end
    end

    // Storage arrays carry no reset; their pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (fifoWr) begin
            fifoMem[fwptr_q] <= m_axi_rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (arHs) begin
            lenQueue[qwptr_q] <= arlen_q;
        end
    end

endmodule

// File: tb/tb_ddr_event_reader.sv
// tb_ddr_event_reader
// -------------------
// Directed bench for ddr_event_reader: an AXI read slave model returns a
// data pattern derived from each beat address, and a stream monitor checks
// every delivered beat against the pattern expected from the command.

module tb_ddr_event_reader;

    localparam int AW = 34;
    localparam int DW = 512;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [15:0]   cmd_beats = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b1;
    logic          m_axi_rid = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          done;
    logic          err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } arEntry_t;

    arEntry_t      slaveQ[$];
    arEntry_t      arLog[$];
    arEntry_t      newAr;
    int            rBeatIdx = 0;
    int            rGlobal = 0;
    int            errBeat = -1;
    bit            rHold = 1'b0;

    int            cyc = 0;
    int            vectorCount = 0;
    int            missCount = 0;
    logic [AW-1:0] expBase = '0;
    int            expTotal = 0;
    int            streamIdx = 0;
    int            tvalidCount = 0;
    int            doneCount = 0;
    int            doneEdge = 0;
    int            lastHsEdge = 0;
    int            acceptEdge = 0;

    ddr_event_reader dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .done          (done),
        .err           (err)
    );

    // 10-unit clock; cyc counts rising edges.
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        cyc = cyc + 1;
    end

    // Address-derived data pattern so ordering and addressing errors show up.
    function automatic logic [DW-1:0] beatData(input logic [AW-1:0] a);
        logic [63:0]   lane;
        logic [DW-1:0] d;
        lane = {32'hC0DE_0000 ^ 32'(a >> 6), a[31:0]};
        for (int k = 0; k < DW / 64; k++) begin
            d[k*64 +: 64] = lane ^ 64'(k);
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                               input logic [DW-1:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // AXI read slave, evaluated on the falling edge. An R beat presented here
    // is consumed at the next rising edge (rready is high). AR is logged here
    // when it will handshake at the next rising edge; its data starts a cycle
    // after that handshake.
    always @(negedge aclk) begin
        if (!aresetn) begin
            slaveQ.delete();
            rBeatIdx = 0;
            m_axi_rvalid = 1'b0;
            m_axi_rlast = 1'b0;
            m_axi_rresp = 2'b00;
        end else begin
            if (slaveQ.size() > 0 && !rHold) begin
                m_axi_rdata  = beatData(slaveQ[0].addr + AW'(rBeatIdx * 64));
                m_axi_rlast  = (rBeatIdx == int'(slaveQ[0].len));
                m_axi_rresp  = (rGlobal == errBeat) ? 2'b10 : 2'b00;
                m_axi_rvalid = 1'b1;
                rGlobal++;
                if (m_axi_rlast) begin
                    void'(slaveQ.pop_front());
                    rBeatIdx = 0;
                end else begin
                    rBeatIdx++;
                end
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast = 1'b0;
                m_axi_rresp = 2'b00;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                newAr.addr = m_axi_araddr;
                newAr.len = m_axi_arlen;
                slaveQ.push_back(newAr);
                arLog.push_back(newAr);
            end
        end
    end

    // Stream monitor: checks each handshaking beat and records done pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid) begin
                tvalidCount++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checkOutput("tdata", m_axis_tdata, beatData(expBase + AW'(streamIdx * 64)));
                checkOutput("tlast", DW'(m_axis_tlast), DW'(streamIdx == expTotal - 1));
                streamIdx++;
                lastHsEdge = cyc + 1;
            end
            if (done) begin
                doneCount++;
                doneEdge = cyc;
            end
        end
    end

    // Presents one command and holds cmd_valid until it is accepted.
    task automatic applyStimulus(input logic [AW-1:0] addr, input int beats);
        bit accepted;
        arLog.delete();
        expBase = {addr[AW-1:6], 6'b0};
        expTotal = beats;
        streamIdx = 0;
        tvalidCount = 0;
        rGlobal = 0;
        cmd_addr = addr;
        cmd_beats = 16'(beats);
        cmd_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin
                accepted = 1'b1;
                acceptEdge = cyc + 1;
            end
        end
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", DW'(accepted), DW'(1));
    endtask

    task automatic waitDone(input int maxCyc);
        int startCount;
        startCount = doneCount;
        for (int i = 0; i < maxCyc && doneCount == startCount; i++) begin
            @(posedge aclk);
        end
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("done_pulses", DW'(doneCount - startCount), DW'(1));
    endtask

    task automatic checkAr(input string tag, input int idx, input logic [AW-1:0] addr,
                           input logic [7:0] len);
        logic [AW-1:0] gotAddr;
        logic [7:0]    gotLen;
        gotAddr = '1;
        gotLen = '1;
        if (idx < arLog.size()) begin
            gotAddr = arLog[idx].addr;
            gotLen = arLog[idx].len;
        end
        checkOutput({tag, "_addr"}, DW'(gotAddr), DW'(addr));
        checkOutput({tag, "_len"}, DW'(gotLen), DW'(len));
    endtask

    initial begin
        logic [AW-1:0] splitAddr [4];
        logic [7:0]    splitLen [4];
        bit            reached;

        splitAddr = '{34'h0FC0, 34'h1000, 34'h2000, 34'h3000};
        splitLen  = '{8'd0, 8'd63, 8'd63, 8'd0};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        checkOutput("rst_arvalid", DW'(m_axi_arvalid), DW'(0));
        checkOutput("rst_rready", DW'(m_axi_rready), DW'(0));
        checkOutput("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        checkOutput("rst_done", DW'(done), DW'(0));
        checkOutput("rst_err", DW'(err), DW'(0));
        checkOutput("rst_arsize", DW'(m_axi_arsize), DW'(6));
        checkOutput("rst_arburst", DW'(m_axi_arburst), DW'(1));
        checkOutput("rst_arcache", DW'(m_axi_arcache), DW'(3));
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checkOutput("idle_cmd_ready", DW'(cmd_ready), DW'(1));
        checkOutput("idle_rready", DW'(m_axi_rready), DW'(1));

        // Single 8-beat burst
        $display("[TB] 8-beat read at 0x1000");
        applyStimulus(34'h1000, 8);
        waitDone(200);
        checkOutput("t1_ar_count", DW'(arLog.size()), DW'(1));
        checkAr("t1_ar0", 0, 34'h1000, 8'd7);
        checkOutput("t1_beats", DW'(streamIdx), DW'(8));
        checkOutput("t1_done_latency", DW'(doneEdge), DW'(lastHsEdge));
        checkOutput("t1_err", DW'(err), DW'(0));

        // Page-split: 1 + 64 + 64 + 1 beats
        $display("[TB] 130-beat read at 0xFC0");
        applyStimulus(34'h0FC0, 130);
        waitDone(1000);
        checkOutput("t2_ar_count", DW'(arLog.size()), DW'(4));
        for (int i = 0; i < 4; i++) begin
            checkAr($sformatf("t2_ar%0d", i), i, splitAddr[i], splitLen[i]);
        end
        checkOutput("t2_beats", DW'(streamIdx), DW'(130));

        // Back-pressure: reservation limits issue to four 64-beat bursts
        $display("[TB] 1024-beat read with stream stalled");
        m_axis_tready = 1'b0;
        applyStimulus(34'h20000, 1024);
        repeat (400) @(posedge aclk);
        #1;
        checkOutput("t3_ar_stalled", DW'(arLog.size()), DW'(4));
        checkOutput("t3_arvalid_low", DW'(m_axi_arvalid), DW'(0));
        checkAr("t3_ar3", 3, 34'h23000, 8'd63);
        m_axis_tready = 1'b1;
        waitDone(5000);
        checkOutput("t3_ar_count", DW'(arLog.size()), DW'(16));
        checkAr("t3_ar15", 15, 34'h2F000, 8'd63);
        checkOutput("t3_beats", DW'(streamIdx), DW'(1024));
        checkOutput("t3_err", DW'(err), DW'(0));

        // Error response on beat 3 is flagged but data still flows
        $display("[TB] 8-beat read with SLVERR on beat 3");
        errBeat = 2;
        applyStimulus(34'h5000, 8);
        waitDone(200);
        errBeat = -1;
        checkOutput("t4_err", DW'(err), DW'(1));
        checkOutput("t4_beats", DW'(streamIdx), DW'(8));

        // Zero-length command; its acceptance also clears err
        $display("[TB] zero-beat command");
        applyStimulus(34'h6000, 0);
        checkOutput("t5_err_cleared", DW'(err), DW'(0));
        waitDone(20);
        checkOutput("t5_done_latency", DW'(doneEdge), DW'(acceptEdge + 1));
        checkOutput("t5_no_ar", DW'(arLog.size()), DW'(0));
        checkOutput("t5_no_tvalid", DW'(tvalidCount), DW'(0));

        // Reset with three bursts outstanding
        $display("[TB] reset mid-command");
        m_axis_tready = 1'b0;
        rHold = 1'b1;
        applyStimulus(34'h8000, 256);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(posedge aclk);
            if (arLog.size() >= 3) begin
                reached = 1'b1;
            end
        end
        checkOutput("t6_three_ars", DW'(reached), DW'(1));
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("t6_cmd_ready", DW'(cmd_ready), DW'(0));
        checkOutput("t6_arvalid", DW'(m_axi_arvalid), DW'(0));
        checkOutput("t6_araddr", DW'(m_axi_araddr), DW'(0));
        checkOutput("t6_arlen", DW'(m_axi_arlen), DW'(0));
        checkOutput("t6_rready", DW'(m_axi_rready), DW'(0));
        checkOutput("t6_tvalid", DW'(m_axis_tvalid), DW'(0));
        checkOutput("t6_tdata", m_axis_tdata, DW'(0));
        checkOutput("t6_tlast", DW'(m_axis_tlast), DW'(0));
        checkOutput("t6_done", DW'(done), DW'(0));
        checkOutput("t6_err", DW'(err), DW'(0));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        rHold = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        checkOutput("t6_post_cmd_ready", DW'(cmd_ready), DW'(1));
        checkOutput("t6_post_tvalid", DW'(m_axis_tvalid), DW'(0));
        applyStimulus(34'h9000, 8);
        waitDone(200);
        checkAr("t6_post_ar0", 0, 34'h9000, 8'd7);
        checkOutput("t6_post_beats", DW'(streamIdx), DW'(8));
        checkOutput("t6_post_err", DW'(err), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge aclk);
        $display("[TB] FAIL watchdog: got no finish, expected finish within 60000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
